// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Pure declarations; no timing or flow-control behaviour of its own.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic ID_C = 1'b0;
   localparam logic ID_D = 1'b1;

   // Latency counter must hold MEM_LAT-1; never narrower than one bit.
   function automatic int cnt_width(input int lat);
      return (lat < 1) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/arb_pick2.sv
// Combinational 2-way picker: round-robin against last_gnt or fixed priority to C.
// Zero latency; no backpressure, the loser simply stays pending upstream.
module arb_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_gnt_i,
   input  logic       rr_en_i,
   output logic       winner_o,
   output logic       valid_o
);

   always_comb begin
      valid_o  = |req_i;
      winner_o = ID_C;
      if (req_i == 2'b11) begin
         winner_o = rr_en_i ? ~last_gnt_i : ID_C;
      end else if (req_i[1]) begin
         winner_o = ID_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Core/DMA arbiter for the unified memory: latch one request, drive memory MEM_LAT cycles, ack.
// Ack arrives MEM_LAT+1 cycles after the request is seen in IDLE; requesters hold req until ack.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1,
   parameter int RR_EN   = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_ack,
   output logic [DW-1:0] c_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   output logic          busy,
   output logic          grant_id
);

   localparam int            CW       = cnt_width(MEM_LAT);
   localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

   state_t          state_q, state_d;
   logic            last_gnt_q, last_gnt_d;
   logic            grant_q, grant_d;
   logic            we_q, we_d;
   logic            we_pulse_q, we_pulse_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   c_rdata_q, c_rdata_d;
   logic [DW-1:0]   d_rdata_q, d_rdata_d;

   logic            pick_win;
   logic            pick_vld;

   arb_pick2 u_pick (
      .req_i      ({d_req, c_req}),
      .last_gnt_i (last_gnt_q),
      .rr_en_i    (RR_EN != 0),
      .winner_o   (pick_win),
      .valid_o    (pick_vld)
   );

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      grant_d    = grant_q;
      we_d       = we_q;
      we_pulse_d = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      c_rdata_d  = c_rdata_q;
      d_rdata_d  = d_rdata_q;

      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_d    = pick_win;
               last_gnt_d = pick_win;
               we_d       = (pick_win == ID_D) ? d_we    : c_we;
               addr_d     = (pick_win == ID_D) ? d_addr  : c_addr;
               wdata_d    = (pick_win == ID_D) ? d_wdata : c_wdata;
               we_pulse_d = (pick_win == ID_D) ? d_we    : c_we;
               cnt_d      = CNT_INIT;
               state_d    = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               // Read data is valid on the final ACCESS edge only.
               if (!we_q) begin
                  if (grant_q == ID_D) d_rdata_d = m_rdata;
                  else                 c_rdata_d = m_rdata;
               end
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         last_gnt_q <= ID_D;
         grant_q    <= ID_C;
         we_q       <= 1'b0;
         we_pulse_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         c_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         grant_q    <= grant_d;
         we_q       <= we_d;
         we_pulse_q <= we_pulse_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         c_rdata_q  <= c_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   // Gating with rst keeps a reset cycle from ever committing a write.
   assign m_we     = we_pulse_q & rst;
   assign m_addr   = addr_q;
   assign m_wdata  = wdata_q;
   assign c_ack    = (state_q == DONE) && (grant_q == ID_C);
   assign d_ack    = (state_q == DONE) && (grant_q == ID_D);
   assign c_rdata  = c_rdata_q;
   assign d_rdata  = d_rdata_q;
   assign busy     = (state_q != IDLE);
   assign grant_id = grant_q;

endmodule
